// File: rtl/f1_light_sequencer_if.sv
// rtl/f1_light_sequencer_if.sv - start-light sequencer control/status bundle
// master drives the request side (trigger/tick/abort/delay); slave is the sequencer.
interface f1_light_sequencer_if #(
  parameter int NUM_LIGHTS = 8,
  parameter int DELAY_W    = 7
);
  logic                  trigger;
  logic                  tick;
  logic                  abort;
  logic [DELAY_W-1:0]    delay;
  logic [NUM_LIGHTS-1:0] lights;
  logic                  busy;
  logic                  go;

  modport master (
    output trigger, tick, abort, delay,
    input  lights, busy, go
  );

  modport slave (
    input  trigger, tick, abort, delay,
    output lights, busy, go
  );
endinterface

// File: rtl/f1_light_sequencer.sv
// rtl/f1_light_sequencer.sv - F1 start-light fill/hold/extinguish sequencer
// Lamps fill one per tick, hold for delay+1 ticks, then go out with a one-cycle go strobe.
module f1_light_sequencer #(
  parameter int NUM_LIGHTS = 8,
  parameter int DELAY_W    = 7,
  parameter int REVERSE    = 0
) (
  input  logic                clk,
  input  logic                rst,
  f1_light_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_q, state_n;
  logic [NUM_LIGHTS-1:0] lights_q, lights_n;
  logic [NUM_LIGHTS-1:0] fill_next;
  logic [DELAY_W-1:0]    hold_q, hold_n;
  logic                  go_q, go_n;

  // Shift a new lit lamp in from the end that fills first.
  always_comb begin
    fill_next = lights_q;
    if (REVERSE != 0) begin
      fill_next = {1'b1, lights_q[NUM_LIGHTS-1:1]};
    end else begin
      fill_next = {lights_q[NUM_LIGHTS-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lights_q <= '0;
      hold_q   <= '0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_n;
      lights_q <= lights_n;
      hold_q   <= hold_n;
      go_q     <= go_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    lights_n = lights_q;
    hold_n   = hold_q;
    go_n     = 1'b0;
    if (bus.abort) begin
      state_n  = IDLE;
      lights_n = '0;
      hold_n   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          lights_n = '0;
          if (bus.trigger) begin
            state_n = FILL;
          end
        end
        FILL: begin
          if (bus.tick) begin
            lights_n = fill_next;
            if (&fill_next) begin
              state_n = HOLD;
              hold_n  = bus.delay;
            end
          end
        end
        HOLD: begin
          if (bus.tick) begin
            if (hold_q != '0) begin
              hold_n = hold_q - DELAY_W'(1);
            end else begin
              state_n  = IDLE;
              lights_n = '0;
              go_n     = 1'b1;
            end
          end
        end
        default: begin
          state_n  = IDLE;
          lights_n = '0;
          hold_n   = '0;
        end
      endcase
    end
  end

  assign bus.lights = lights_q;
  assign bus.go     = go_q;
  assign bus.busy   = (state_q == FILL) || (state_q == HOLD);

endmodule

// File: tb/tb_f1_light_sequencer.sv
// tb/tb_f1_light_sequencer.sv - table-driven scoreboard bench for f1_light_sequencer
// Runs LSB-first and MSB-first instances side by side on identical stimulus.
module tb_f1_light_sequencer;

  typedef struct {
    bit         trig;
    bit         tick;
    bit         abort;
    logic [6:0] delay;
    logic [7:0] lf;
    logic [7:0] lr;
    bit         busy;
    bit         go;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  f1_light_sequencer_if #(.NUM_LIGHTS(8), .DELAY_W(7)) if_f ();
  f1_light_sequencer_if #(.NUM_LIGHTS(8), .DELAY_W(7)) if_r ();

  f1_light_sequencer #(.NUM_LIGHTS(8), .DELAY_W(7), .REVERSE(0)) u_fwd (
    .clk (clk),
    .rst (rst),
    .bus (if_f.slave)
  );

  f1_light_sequencer #(.NUM_LIGHTS(8), .DELAY_W(7), .REVERSE(1)) u_rev (
    .clk (clk),
    .rst (rst),
    .bus (if_r.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic add(input bit trig, input bit tick, input bit abort, input logic [6:0] delay,
                     input logic [7:0] lf, input logic [7:0] lr, input bit busy, input bit go);
    vec_t v;
    v.trig = trig; v.tick = tick; v.abort = abort; v.delay = delay;
    v.lf = lf; v.lr = lr; v.busy = busy; v.go = go;
    vecs.push_back(v);
  endtask

  // k ticks of fill: LSB-first has k low bits set, MSB-first has k high bits set.
  task automatic add_fill(input bit trig, input logic [6:0] delay, input int n);
    for (int k = 0; k < n; k++) begin
      add(trig, 1'b1, 1'b0, delay, 8'((1 << (k + 1)) - 1), ~(8'hFF >> (k + 1)), 1'b1, 1'b0);
    end
  endtask

  task automatic drive(input vec_t v);
    if_f.trigger = v.trig;  if_r.trigger = v.trig;
    if_f.tick    = v.tick;  if_r.tick    = v.tick;
    if_f.abort   = v.abort; if_r.abort   = v.abort;
    if_f.delay   = v.delay; if_r.delay   = v.delay;
  endtask

  task automatic check_outputs(input string tag, input int idx, input vec_t e);
    chk({tag, "_lights_fwd"}, idx, if_f.lights, e.lf);
    chk({tag, "_lights_rev"}, idx, if_r.lights, e.lr);
    chk({tag, "_busy_fwd"}, idx, {7'd0, if_f.busy}, {7'd0, e.busy});
    chk({tag, "_busy_rev"}, idx, {7'd0, if_r.busy}, {7'd0, e.busy});
    chk({tag, "_go_fwd"}, idx, {7'd0, if_f.go}, {7'd0, e.go});
    chk({tag, "_go_rev"}, idx, {7'd0, if_r.go}, {7'd0, e.go});
  endtask

  task automatic run_vecs();
    vec_t v;
    vec_t e;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      drive(v);
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_outputs("vec", vec_idx, e);
      vec_idx++;
    end
  endtask

  initial begin
    vec_t zero_v;
    zero_v = '{default: '0};
    drive(zero_v);

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, zero_v);
    rst = 1'b1;

    // basic fill, tick in trigger cycle ignored, delay=3 -> four hold ticks
    add(1, 1, 0, 3, 8'h00, 8'h00, 1, 0);
    add_fill(0, 3, 8);
    repeat (3) add(0, 1, 0, 3, 8'hFF, 8'hFF, 1, 0);
    add(0, 1, 0, 3, 8'h00, 8'h00, 0, 1);
    add(0, 0, 0, 3, 8'h00, 8'h00, 0, 0);

    // delay=0: lamps go out on the first tick after full
    add(1, 0, 0, 0, 8'h00, 8'h00, 1, 0);
    add_fill(0, 0, 8);
    add(0, 1, 0, 0, 8'h00, 8'h00, 0, 1);
    add(0, 1, 0, 0, 8'h00, 8'h00, 0, 0);

    // abort after five ticks beats a simultaneous trigger and tick
    add(1, 0, 0, 2, 8'h00, 8'h00, 1, 0);
    add_fill(0, 2, 5);
    add(0, 0, 0, 2, 8'h1F, 8'hF8, 1, 0);
    add(1, 1, 1, 2, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 2, 8'h00, 8'h00, 0, 0);
    add(1, 0, 0, 2, 8'h00, 8'h00, 1, 0);
    add(0, 1, 0, 2, 8'h01, 8'h80, 1, 0);
    add(0, 0, 1, 2, 8'h00, 8'h00, 0, 0);
    add(1, 0, 1, 2, 8'h00, 8'h00, 0, 0);

    // abort during hold gives no go
    add(1, 0, 0, 9, 8'h00, 8'h00, 1, 0);
    add_fill(0, 9, 8);
    add(0, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h00, 0, 0);

    // trigger held through the run: no restart; trigger in go cycle restarts
    add(1, 0, 0, 1, 8'h00, 8'h00, 1, 0);
    add_fill(1, 1, 8);
    add(1, 1, 0, 1, 8'hFF, 8'hFF, 1, 0);
    add(1, 1, 0, 1, 8'h00, 8'h00, 0, 1);
    add(1, 0, 0, 1, 8'h00, 8'h00, 1, 0);
    add(0, 1, 0, 1, 8'h01, 8'h80, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h00, 0, 0);

    // delay=5 latched, then changed to 1: still six ticks after full
    add(1, 0, 0, 5, 8'h00, 8'h00, 1, 0);
    add_fill(0, 5, 8);
    add(0, 0, 0, 1, 8'hFF, 8'hFF, 1, 0);
    repeat (5) add(0, 1, 0, 1, 8'hFF, 8'hFF, 1, 0);
    add(0, 1, 0, 1, 8'h00, 8'h00, 0, 1);
    add(0, 0, 0, 1, 8'h00, 8'h00, 0, 0);

    // lead-in to an asynchronous reset in the middle of hold
    add(1, 0, 0, 4, 8'h00, 8'h00, 1, 0);
    add_fill(0, 4, 8);
    repeat (2) add(0, 1, 0, 4, 8'hFF, 8'hFF, 1, 0);
    run_vecs();

    #2;
    rst = 1'b0;
    #1;
    check_outputs("async_rst", 0, zero_v);
    #3;
    rst = 1'b1;

    repeat (3) add(0, 1, 0, 4, 8'h00, 8'h00, 0, 0);
    add(1, 0, 0, 4, 8'h00, 8'h00, 1, 0);
    add(0, 1, 0, 4, 8'h01, 8'h80, 1, 0);
    run_vecs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
